// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC controller and its event counters.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam int          CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC sequencer: boot cycle, sequential/stalled fetch, taken-branch redirect
// with a fixed-length wrong-path squash, plus branch statistics.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2               // 1..7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch,
  input  logic             zero,
  input  logic [31:0]      branch_target,
  input  logic             stall,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             PCSrc,
  output logic             flush,
  output logic             addr_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        pc_valid_q;
  logic        flush_q;
  logic        addr_err_q;
  logic [2:0]  fcnt_q;

  logic        accept;
  logic        pc_src;
  logic [31:0] pc_seq_d;
  logic [31:0] pc_tgt_d;

  // Branches are only honoured in RUN; during BOOT/FLUSH the EX slot is wrong-path.
  assign accept   = (state_q == RUN) && branch;
  assign pc_src   = accept && zero;
  assign pc_seq_d = stall ? pc_q : (pc_q + PC_INC);
  assign pc_tgt_d = {branch_target[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      addr_err_q <= 1'b0;
      fcnt_q     <= 3'd0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
          flush_q    <= 1'b0;
        end
        RUN: begin
          if (pc_src) begin
            pc_q    <= pc_tgt_d;
            state_q <= FLUSH;
            flush_q <= 1'b1;
            fcnt_q  <= FLUSH_LOAD;
            if (branch_target[1:0] != 2'b00) addr_err_q <= 1'b1;
          end else begin
            pc_q <= pc_seq_d;
          end
        end
        FLUSH: begin
          // Counter runs even while stalled so the squash window has a fixed length.
          pc_q   <= pc_seq_d;
          fcnt_q <= fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
          flush_q    <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (accept),
    .cnt_o (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pc_src),
    .cnt_o (taken_cnt)
  );

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign PCSrc    = pc_src;
  assign flush    = flush_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed table, reset corner cases and randomized model comparison for pc_ctrl.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int          NFL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch, zero, stall;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        pc_valid, PCSrc, flush, addr_err;
  logic [15:0] branch_cnt, taken_cnt;

  logic        sat_rst_n, sat_en;
  logic [3:0]  sat_cnt;

  always #5 clk = ~clk;

  pc_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(NFL)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .zero(zero),
    .branch_target(branch_target), .stall(stall), .pc(pc), .pc_valid(pc_valid),
    .PCSrc(PCSrc), .flush(flush), .addr_err(addr_err),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  sat_counter #(.WIDTH(4)) u_sat (
    .clk(clk), .rst_n(sat_rst_n), .en_i(sat_en), .cnt_o(sat_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining boot/flush cycles as plain integers.
  logic [31:0] m_pc;
  bit          m_boot;
  int          m_fl;
  bit          m_err;
  int          m_bc, m_tc;

  task automatic model_reset();
    m_pc = RPC; m_boot = 1'b1; m_fl = 0; m_err = 1'b0; m_bc = 0; m_tc = 0;
  endtask

  function automatic bit model_taken(input logic b, input logic z);
    return !m_boot && (m_fl == 0) && b && z;
  endfunction

  task automatic model_step(input logic b, input logic z, input logic [31:0] t, input logic s);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_fl > 0) begin
      m_fl--;
      if (!s) m_pc = m_pc + 32'd4;
    end else begin
      if (b && m_bc < 65535) m_bc++;
      if (b && z) begin
        if (m_tc < 65535) m_tc++;
        m_pc = t & 32'hFFFF_FFFC;
        m_fl = NFL;
        if (t[1:0] != 2'b00) m_err = 1'b1;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},       pc,                  m_pc);
    chk({tag, ".pc_valid"}, 32'(pc_valid),       32'(!m_boot));
    chk({tag, ".flush"},    32'(flush),          32'(m_fl > 0));
    chk({tag, ".addr_err"}, 32'(addr_err),       32'(m_err));
    chk({tag, ".bcnt"},     32'(branch_cnt),     32'(m_bc));
    chk({tag, ".tcnt"},     32'(taken_cnt),      32'(m_tc));
  endtask

  typedef struct {
    logic        br, z;
    logic [31:0] tgt;
    logic        st;
    logic        exp_src;
    logic [31:0] exp_pc;
    logic        exp_fl, exp_err;
    logic [15:0] exp_bc, exp_tc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic br, input logic z, input logic [31:0] tgt,
                              input logic st, input logic src, input logic [31:0] epc,
                              input logic fl, input logic err, input logic [15:0] bc,
                              input logic [15:0] tc);
    vec_t v;
    v.br = br; v.z = z; v.tgt = tgt; v.st = st; v.exp_src = src; v.exp_pc = epc;
    v.exp_fl = fl; v.exp_err = err; v.exp_bc = bc; v.exp_tc = tc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rb, rz, rs;
    logic [31:0] rt;

    rst_n = 1'b0; branch = 1'b0; zero = 1'b0; stall = 1'b0; branch_target = '0;
    sat_rst_n = 1'b0; sat_en = 1'b0;

    //            br z  target        st src pc_after      fl err bc tc
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0040_0000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0040_0004, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0040_0008, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 32'h0000_0100, 0, 1, 32'h0000_0100, 1, 0, 1, 1);
    vecs[4]  = mk(1, 1, 32'h0000_0200, 0, 0, 32'h0000_0104, 1, 0, 1, 1);
    vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0000_0108, 0, 0, 1, 1);
    vecs[6]  = mk(1, 0, 32'h0000_0400, 0, 0, 32'h0000_010C, 0, 0, 2, 1);
    vecs[7]  = mk(1, 0, 32'h0000_0400, 1, 0, 32'h0000_010C, 0, 0, 3, 1);
    vecs[8]  = mk(0, 0, 32'h0,        1, 0, 32'h0000_010C, 0, 0, 3, 1);
    vecs[9]  = mk(1, 1, 32'h0000_0102, 1, 1, 32'h0000_0100, 1, 1, 4, 2);
    vecs[10] = mk(0, 0, 32'h0,        1, 0, 32'h0000_0100, 1, 1, 4, 2);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0000_0104, 0, 1, 4, 2);
    vecs[12] = mk(1, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1, 1, 5, 3);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 32'h0000_0000, 1, 1, 5, 3);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 32'h0000_0004, 0, 1, 5, 3);

    repeat (3) @(posedge clk);
    #1;
    branch = 1'b1; zero = 1'b1; #1;
    chk("rst.pc",       pc,               RPC);
    chk("rst.pc_valid", 32'(pc_valid),    32'd0);
    chk("rst.flush",    32'(flush),       32'd0);
    chk("rst.addr_err", 32'(addr_err),    32'd0);
    chk("rst.bcnt",     32'(branch_cnt),  32'd0);
    chk("rst.tcnt",     32'(taken_cnt),   32'd0);
    chk("rst.pcsrc",    32'(PCSrc),       32'd0);
    branch = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("boot.pc_valid", 32'(pc_valid), 32'd0);

    for (int i = 0; i < 15; i++) begin
      branch = vecs[i].br; zero = vecs[i].z; branch_target = vecs[i].tgt; stall = vecs[i].st;
      #1;
      chk($sformatf("vec%0d.pcsrc", i), 32'(PCSrc), 32'(vecs[i].exp_src));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.pc", i),       pc,               vecs[i].exp_pc);
      chk($sformatf("vec%0d.pc_valid", i), 32'(pc_valid),    32'd1);
      chk($sformatf("vec%0d.flush", i),    32'(flush),       32'(vecs[i].exp_fl));
      chk($sformatf("vec%0d.addr_err", i), 32'(addr_err),    32'(vecs[i].exp_err));
      chk($sformatf("vec%0d.bcnt", i),     32'(branch_cnt),  32'(vecs[i].exp_bc));
      chk($sformatf("vec%0d.tcnt", i),     32'(taken_cnt),   32'(vecs[i].exp_tc));
    end

    // Reset asserted mid-flush: outputs drop immediately, then BOOT, then RUN.
    branch = 1'b1; zero = 1'b1; branch_target = 32'h0000_0300; stall = 1'b0;
    @(posedge clk); #1;
    chk("mf.flush_before", 32'(flush), 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("mf.flush",    32'(flush),      32'd0);
    chk("mf.pc",       pc,              RPC);
    chk("mf.pc_valid", 32'(pc_valid),   32'd0);
    chk("mf.addr_err", 32'(addr_err),   32'd0);
    chk("mf.bcnt",     32'(branch_cnt), 32'd0);
    chk("mf.pcsrc",    32'(PCSrc),      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; branch = 1'b0; zero = 1'b0;
    chk("mf.boot_valid", 32'(pc_valid), 32'd0);
    @(posedge clk); #1;
    chk("mf.run_valid", 32'(pc_valid), 32'd1);
    chk("mf.run_flush", 32'(flush),     32'd0);
    chk("mf.run_pc",    pc,             RPC);
    @(posedge clk); #1;
    chk("mf.run_pc2",   pc,             RPC + 32'd4);
    chk("mf.run_flush2", 32'(flush),    32'd0);

    // Randomized run against the model, with one extra reset in the middle.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_model("rnd.init");
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        rst_n = 1'b0; #1;
        model_reset();
        check_model("rnd.midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      rb = ($urandom_range(0, 2) == 0);
      rz = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) == 0);
      rt = $urandom;
      if ($urandom_range(0, 1) == 1) rt[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rt = 32'hFFFF_FFF4;
      branch = rb; zero = rz; stall = rs; branch_target = rt;
      #1;
      chk("rnd.pcsrc", 32'(PCSrc), 32'(model_taken(rb, rz)));
      model_step(rb, rz, rt, rs);
      @(posedge clk); #1;
      check_model($sformatf("rnd%0d", i));
    end
    branch = 1'b0; zero = 1'b0; stall = 1'b0;

    // Saturation of the shared counter block at a small width.
    sat_rst_n = 1'b1; sat_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sat.count3", 32'(sat_cnt), 32'd3);
    repeat (17) @(posedge clk);
    #1;
    chk("sat.hold15", 32'(sat_cnt), 32'd15);
    sat_en = 1'b0; sat_rst_n = 1'b0; #1;
    chk("sat.clear", 32'(sat_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
